// File: rtl/pixel_pkg.sv
// Shared definitions for the Nios pixel PIO bridge.
//   PIX_W          stream pixel width ({R,G,B})
//   PIO_W          width of the Nios control/status PIOs
//   CTRL_*         bit positions within ctrl_pio
//   STAT_*         bit positions within status_pio
//   pixel_t        FIFO entry: start-of-frame flag plus 8-bit R, G, B
package pixel_pkg;

  localparam int PIX_W = 24;
  localparam int PIO_W = 18;

  localparam int CTRL_STB    = 0;
  localparam int CTRL_SOF    = 1;
  localparam int CTRL_OVFCLR = 2;

  localparam int STAT_ACK     = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_EMPTY   = 3;
  localparam int STAT_LVL_LSB = 4;

  typedef struct packed {
    logic       sof;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Stream data word of a pixel, R in the top byte.
  function automatic logic [PIX_W-1:0] pixel_rgb(input pixel_t p);
    return {p.r, p.g, p.b};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through FIFO with a registered head word.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_din   write request and data (ignored when full unless popping)
//   i_pop           read request (ignored when empty)
//   o_dout          head word, valid whenever o_empty is low
//   o_full/o_empty  flags derived from the registered count
//   o_count         number of stored words, 0..DEPTH
// The head word lives in r_head; the array holds the remaining words, so
// the array never holds more than DEPTH-1 entries.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;

  logic w_push;
  logic w_pop;
  logic w_head_from_din;
  logic w_head_from_mem;
  logic w_mem_wr;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_head;

  always_comb begin
    w_pop  = i_pop && !o_empty;
    w_push = i_push && (!o_full || w_pop);
    // Incoming word goes straight to the head when it becomes the only word.
    w_head_from_din = w_push && (o_empty || (w_pop && (r_count == CNT_W'(1))));
    w_head_from_mem = w_pop && (r_count > CNT_W'(1));
    w_mem_wr        = w_push && !w_head_from_din;
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_mem_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_head_from_mem) begin
        r_head   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end else if (w_head_from_din) begin
        r_head <= i_din;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_pio_bridge.sv
// Captures pixels written by Nios over PIOs, buffers them and presents a
// valid/ready {R,G,B} stream.
//   clk_clk, reset_reset_n       clock, asynchronous active-low reset
//   red/green/blue_pio           pixel components from Nios
//   ctrl_pio                     [0] strobe toggle, [1] sof, [2] overflow clear
//   status_pio                   [0] ack toggle, [1] full, [2] overflow,
//                                [3] empty, [3+CNT_W:4] fill level
//   red/green/blue_echo          last accepted pixel
//   m_valid, m_ready, m_data, m_sof   output pixel stream
module pixel_pio_bridge
  import pixel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [7:0]        red_pio,
  input  logic [7:0]        green_pio,
  input  logic [7:0]        blue_pio,
  input  logic [PIO_W-1:0]  ctrl_pio,
  output logic [PIO_W-1:0]  status_pio,
  output logic [7:0]        red_echo,
  output logic [7:0]        green_echo,
  output logic [7:0]        blue_echo,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_sof
);

  logic       r_prev_tgl;
  logic       r_ack;
  logic       r_ovf;
  logic [7:0] r_red_echo;
  logic [7:0] r_green_echo;
  logic [7:0] r_blue_echo;

  logic             w_evt;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  pixel_t           w_pix_in;
  pixel_t           w_pix_out;
  logic [14:0]      w_unused_ctrl;

  assign w_unused_ctrl = ctrl_pio[PIO_W-1:3];

  // Same clock domain as the PIO, so the toggle is compared directly.
  assign w_evt  = ctrl_pio[CTRL_STB] ^ r_prev_tgl;
  assign w_pop  = !w_empty && m_ready;
  // A full FIFO still accepts the pixel when the head leaves this cycle.
  assign w_push = w_evt && (!w_full || w_pop);
  assign w_drop = w_evt && w_full && !w_pop;

  always_comb begin
    w_pix_in.sof = ctrl_pio[CTRL_SOF];
    w_pix_in.r   = red_pio;
    w_pix_in.g   = green_pio;
    w_pix_in.b   = blue_pio;
  end

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(pixel_t)),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_push  (w_push),
    .i_din   (w_pix_in),
    .i_pop   (w_pop),
    .o_dout  (w_pix_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_prev_tgl   <= 1'b0;
      r_ack        <= 1'b0;
      r_ovf        <= 1'b0;
      r_red_echo   <= '0;
      r_green_echo <= '0;
      r_blue_echo  <= '0;
    end else begin
      r_prev_tgl <= ctrl_pio[CTRL_STB];
      r_ack      <= r_ack ^ w_evt;
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ctrl_pio[CTRL_OVFCLR]) begin
        r_ovf <= 1'b0;
      end
      if (w_push) begin
        r_red_echo   <= red_pio;
        r_green_echo <= green_pio;
        r_blue_echo  <= blue_pio;
      end
    end
  end

  always_comb begin
    status_pio                          = '0;
    status_pio[STAT_ACK]                = r_ack;
    status_pio[STAT_FULL]               = w_full;
    status_pio[STAT_OVF]                = r_ovf;
    status_pio[STAT_EMPTY]              = w_empty;
    status_pio[STAT_LVL_LSB +: CNT_W]   = w_count;
  end

  assign red_echo   = r_red_echo;
  assign green_echo = r_green_echo;
  assign blue_echo  = r_blue_echo;
  assign m_valid    = !w_empty;
  assign m_data     = pixel_rgb(w_pix_out);
  assign m_sof      = w_pix_out.sof;

endmodule

// File: tb/tb_pixel_pio_bridge.sv
module tb_pixel_pio_bridge;

  localparam int DEPTH = 16;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [7:0]  red_pio = '0;
  logic [7:0]  green_pio = '0;
  logic [7:0]  blue_pio = '0;
  logic [17:0] ctrl_pio = '0;
  logic [17:0] status_pio;
  logic [7:0]  red_echo;
  logic [7:0]  green_echo;
  logic [7:0]  blue_echo;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic        m_sof;

  pixel_pio_bridge #(.DEPTH(DEPTH), .CNT_W(5)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .red_pio       (red_pio),
    .green_pio     (green_pio),
    .blue_pio      (blue_pio),
    .ctrl_pio      (ctrl_pio),
    .status_pio    (status_pio),
    .red_echo      (red_echo),
    .green_echo    (green_echo),
    .blue_echo     (blue_echo),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_sof         (m_sof)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the FIFO as a queue of {sof,rgb}, plus the Nios-visible flags.
  logic [24:0] mdl_q[$];
  logic        mdl_ack;
  logic        mdl_ovf;
  logic [23:0] mdl_echo;
  logic        tgl;

  typedef struct {
    bit          flip;
    bit          sof;
    bit          clr;
    bit          rdy;
    logic [23:0] rgb;
    logic [17:0] exp_status;
    bit          exp_valid;
    logic [24:0] exp_head;
    logic [23:0] exp_echo;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] mdl_status();
    logic [17:0] s;
    int n;
    n = mdl_q.size();
    s = '0;
    s[0] = mdl_ack;
    s[1] = (n == DEPTH);
    s[2] = mdl_ovf;
    s[3] = (n == 0);
    s[8:4] = 5'(n);
    return s;
  endfunction

  // One clock of Nios/stream activity followed by a full comparison against the model.
  task automatic step(input bit flip, input bit sof, input bit clr, input bit rdy,
                      input logic [23:0] rgb);
    bit          stalled;
    bit          pop;
    logic [24:0] stall_word;
    if (flip) tgl = ~tgl;
    ctrl_pio = {15'b0, clr, sof, tgl};
    {red_pio, green_pio, blue_pio} = rgb;
    m_ready = rdy;
    stalled = m_valid && !rdy;
    stall_word = {m_sof, m_data};
    @(posedge clk_clk);
    pop = (mdl_q.size() != 0) && rdy;
    if (pop) begin
      $display("pop  data=%06h sof=%0b", mdl_q[0][23:0], mdl_q[0][24]);
      void'(mdl_q.pop_front());
    end
    if (flip && mdl_q.size() < DEPTH) begin
      mdl_q.push_back({sof, rgb});
      mdl_echo = rgb;
    end else if (flip) begin
      mdl_ovf = 1'b1;
    end else if (clr) begin
      mdl_ovf = 1'b0;
    end
    if (flip && clr && mdl_q.size() < DEPTH) mdl_ovf = 1'b0;
    mdl_ack = mdl_ack ^ flip;
    #1;
    chk("status", 32'(status_pio), 32'(mdl_status()));
    chk("m_valid", 32'(m_valid), 32'(mdl_q.size() != 0));
    if (mdl_q.size() != 0) chk("m_head", 32'({m_sof, m_data}), 32'(mdl_q[0]));
    chk("echo", 32'({red_echo, green_echo, blue_echo}), 32'(mdl_echo));
    if (stalled) chk("stall_stable", 32'({m_sof, m_data}), 32'(stall_word));
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ctrl_pio = {16'b0, 1'b1, i[0]};
      {red_pio, green_pio, blue_pio} = 24'($urandom);
      m_ready = 1'b1;
      @(posedge clk_clk);
    end
    #1;
    chk("rst_status", 32'(status_pio), 32'h00008);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_data", 32'({m_sof, m_data}), 32'h0);
    chk("rst_echo", 32'({red_echo, green_echo, blue_echo}), 32'h0);
    ctrl_pio = '0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    mdl_q.delete();
    mdl_ack = 1'b0;
    mdl_ovf = 1'b0;
    mdl_echo = '0;
    tgl = 1'b0;
  endtask

  initial begin
    logic [23:0] got[$];
    logic        ack0;
    int          events;

    //            flip sof clr rdy rgb         status    valid head          echo
    tbl[0] = '{1, 1, 0, 1, 24'h123456, 18'h00011, 1, 25'h1123456, 24'h123456};
    tbl[1] = '{0, 0, 0, 1, 24'h999999, 18'h00009, 0, 25'h0,       24'h123456};
    tbl[2] = '{1, 0, 0, 0, 24'hABCDEF, 18'h00010, 1, 25'h0ABCDEF, 24'hABCDEF};
    tbl[3] = '{0, 0, 0, 0, 24'h777777, 18'h00010, 1, 25'h0ABCDEF, 24'hABCDEF};
    tbl[4] = '{0, 0, 0, 1, 24'h555555, 18'h00008, 0, 25'h0,       24'hABCDEF};

    do_reset();

    // Single pixels through an empty FIFO.
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].flip, tbl[i].sof, tbl[i].clr, tbl[i].rdy, tbl[i].rgb);
      $display("vec %0d status=%05h valid=%0b data=%06h", i, status_pio, m_valid, m_data);
      chk("tbl_status", 32'(status_pio), 32'(tbl[i].exp_status));
      chk("tbl_valid", 32'(m_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk("tbl_head", 32'({m_sof, m_data}), 32'(tbl[i].exp_head));
      chk("tbl_echo", 32'({red_echo, green_echo, blue_echo}), 32'(tbl[i].exp_echo));
    end

    // Fill past capacity with the stream stalled.
    ack0 = mdl_ack;
    for (int i = 0; i < 17; i++) begin
      step(1, (i == 0), 0, 0, 24'h100000 + 24'(i));
      if (i == 15) begin
        chk("fill_full", 32'(status_pio[1]), 32'h1);
        chk("fill_lvl", 32'(status_pio[8:4]), 32'd16);
        chk("fill_noovf", 32'(status_pio[2]), 32'h0);
      end
    end
    chk("fill_ovf", 32'(status_pio[2]), 32'h1);
    chk("fill_ack", 32'(status_pio[0]), 32'(ack0 ^ 1'b1));
    chk("drop_echo", 32'({red_echo, green_echo, blue_echo}), 32'h10000F);
    for (int i = 0; i < 20; i++) begin
      if (m_valid) got.push_back(m_data);
      step(0, 0, 0, 1, 24'h0);
    end
    chk("drain_cnt", 32'(got.size()), 32'd16);
    chk("drain_last", 32'(got[$]), 32'h10000F);

    // Overflow clear, then a drop coinciding with a clear.
    step(0, 0, 1, 0, 24'h0);
    chk("ovf_clr", 32'(status_pio[2]), 32'h0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 24'h200000 + 24'(i));
    step(1, 0, 1, 0, 24'h2DEAD0);
    chk("ovf_set_wins", 32'(status_pio[2]), 32'h1);
    chk("ovf_drop_lvl", 32'(status_pio[8:4]), 32'd16);
    step(0, 0, 1, 0, 24'h0);
    chk("ovf_clr2", 32'(status_pio[2]), 32'h0);

    // Full FIFO with a pop in the event cycle: pixel accepted, level unchanged.
    step(1, 0, 0, 1, 24'h2ABCDE);
    chk("fullpop_ovf", 32'(status_pio[2]), 32'h0);
    chk("fullpop_lvl", 32'(status_pio[8:4]), 32'd16);
    got.delete();
    for (int i = 0; i < 20; i++) begin
      if (m_valid) got.push_back(m_data);
      step(0, 0, 0, 1, 24'h0);
    end
    chk("fullpop_cnt", 32'(got.size()), 32'd16);
    chk("fullpop_first", 32'(got[0]), 32'h200001);
    chk("fullpop_last", 32'(got[$]), 32'h2ABCDE);

    // Random traffic with random back-pressure.
    events = 0;
    for (int c = 0; c < 3000 && events < 200; c++) begin
      bit f;
      f = ($urandom_range(0, 99) < 40);
      step(f, 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 99) < 55), 24'($urandom));
      if (f) events++;
    end
    chk("rand_events", 32'(events), 32'd200);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 24'h0);

    // Reset in the middle of a frame discards the FIFO and clears ack.
    step(1, 1, 0, 0, 24'h010203);
    step(1, 0, 0, 0, 24'h040506);
    step(1, 0, 0, 0, 24'h070809);
    do_reset();
    step(0, 0, 0, 1, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
